// File: rtl/cdc_pkg.sv
// cdc_pkg
// Shared constants and helpers for the clock-domain-crossing synchronizers.
//   CDC_MIN_STAGES / CDC_MAX_STAGES : legal depth range of a sync chain
//   cdc_stages_t                    : type wide enough to hold any legal depth
//   cdc_stages_legal()              : range check used at elaboration time
package cdc_pkg;

   localparam int CDC_MIN_STAGES = 2;
   localparam int CDC_MAX_STAGES = 8;

   // Holds any depth in CDC_MIN_STAGES..CDC_MAX_STAGES.
   typedef logic [3:0] cdc_stages_t;

   function automatic logic cdc_stages_legal(input int stages);
      return (stages >= CDC_MIN_STAGES) && (stages <= CDC_MAX_STAGES);
   endfunction

endpackage : cdc_pkg

// File: rtl/sync_bit_chain.sv
// sync_bit_chain
// One-bit flip-flop synchronizer chain, STAGES flops deep.
// Ports:
//   i_clk   in  1  destination-domain clock (rising edge)
//   i_rst_n in  1  synchronous reset, active-high despite the name
//   i_d     in  1  asynchronous input level
//   o_q     out 1  synchronized level (last flop of the chain)
module sync_bit_chain
   import cdc_pkg::*;
#(
   parameter int   STAGES    = CDC_MIN_STAGES,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   // Every flop here may go metastable; keep them adjacent and un-retimed.
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_stage;

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_stage <= {STAGES{RESET_VAL}};
      end else begin
         r_stage[0] <= i_d;
         for (int k = 1; k < STAGES; k++) begin
            r_stage[k] <= r_stage[k-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule : sync_bit_chain

// File: rtl/double_ff_synch.sv
// double_ff_synch
// Multi-stage synchronizer bringing an asynchronous level (or vector of
// independent levels) into the i_clk domain, with per-bit edge pulses.
// Bits are synchronized independently: no coherency across bits.
// Ports:
//   i_clk   in  1      destination-domain clock (rising edge)
//   i_rst_n in  1      synchronous reset, active-high despite the name
//   i_D     in  WIDTH  asynchronous input level
//   o_q     out WIDTH  synchronized level, STAGES edges behind i_D
//   o_rise  out WIDTH  one-cycle pulse when a bit of o_q goes 0->1
//   o_fall  out WIDTH  one-cycle pulse when a bit of o_q goes 1->0
module double_ff_synch
   import cdc_pkg::*;
#(
   parameter int               STAGES    = 2,
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_D,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);

   // Reject chain depths outside the supported range at elaboration.
   generate
      if (!cdc_stages_legal(STAGES)) begin : g_bad_stages
         $error("double_ff_synch: STAGES=%0d outside %0d..%0d",
                STAGES, CDC_MIN_STAGES, CDC_MAX_STAGES);
      end
      if (WIDTH < 1) begin : g_bad_width
         $error("double_ff_synch: WIDTH=%0d must be at least 1", WIDTH);
      end
   endgenerate

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] r_prev;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chain
         sync_bit_chain #(
            .STAGES    (STAGES),
            .RESET_VAL (RESET_VAL[gi])
         ) u_chain (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (i_D[gi]),
            .o_q     (w_q[gi])
         );
      end
   endgenerate

   // Previous synchronized level. Reset to the same value as the chain so
   // no spurious pulse appears while in reset; the first transition out of
   // RESET_VAL after release is still reported.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_prev <= RESET_VAL;
      end else begin
         r_prev <= w_q;
      end
   end

   // Pulses decode registered state only, never i_D directly.
   assign o_q    = w_q;
   assign o_rise = w_q & ~r_prev;
   assign o_fall = ~w_q & r_prev;

endmodule : double_ff_synch

// File: tb/tb_double_ff_synch.sv
module tb_double_ff_synch;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Default configuration: STAGES=2, WIDTH=1, RESET_VAL=0
   logic       rst_a = 1'b1;
   logic [0:0] d_a   = 1'b0;
   logic [0:0] q_a, rise_a, fall_a;

   // Wide configuration: STAGES=3, WIDTH=4, RESET_VAL=4'hA
   logic       rst_b = 1'b1;
   logic [3:0] d_b   = 4'h0;
   logic [3:0] q_b, rise_b, fall_b;

   int n_checks = 0;
   int n_fail   = 0;

   double_ff_synch u_dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_a),
      .i_D     (d_a),
      .o_q     (q_a),
      .o_rise  (rise_a),
      .o_fall  (fall_a)
   );

   double_ff_synch #(
      .STAGES    (3),
      .WIDTH     (4),
      .RESET_VAL (4'hA)
   ) u_dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_b),
      .i_D     (d_b),
      .o_q     (q_b),
      .o_rise  (rise_b),
      .o_fall  (fall_b)
   );

   // Advance one rising edge, then move off the edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   logic [19:0] pat;
   logic        exp_q, exp_prev, last_d;

   initial begin
      pat = 20'b1011_0010_1110_0101_1001;

      // ---- Reset state, default DUT
      tick(); tick();
      check("rst_q",    q_a,    4'h0);
      check("rst_rise", rise_a, 4'h0);
      check("rst_fall", fall_a, 4'h0);

      // ---- Release with i_D=1: 0 after first edge, 1 (with rise) after second
      rst_a = 1'b0; d_a = 1'b1;
      tick();
      check("rel1_q",    q_a,    4'h0);
      check("rel1_rise", rise_a, 4'h0);
      tick();
      check("rel2_q",    q_a,    4'h1);
      check("rel2_rise", rise_a, 4'h1);
      tick();
      check("rel3_q",    q_a,    4'h1);
      check("rel3_rise", rise_a, 4'h0);

      // ---- 1->0 after settle: fall pulse two edges later, one cycle wide
      d_a = 1'b0;
      tick();
      check("f1_q",    q_a,    4'h1);
      check("f1_fall", fall_a, 4'h0);
      tick();
      check("f2_q",    q_a,    4'h0);
      check("f2_fall", fall_a, 4'h1);
      check("f2_rise", rise_a, 4'h0);
      tick();
      check("f3_fall", fall_a, 4'h0);

      // ---- 20 directed values, one per cycle: o_q is i_D two edges late
      last_d   = 1'b0;
      exp_prev = 1'b0;
      for (int i = 0; i < 20; i++) begin
         d_a = pat[i];
         tick();
         exp_q = last_d;
         check($sformatf("seq%0d_q", i),    q_a,    {3'b0, exp_q});
         check($sformatf("seq%0d_rise", i), rise_a, {3'b0, exp_q & ~exp_prev});
         check($sformatf("seq%0d_fall", i), fall_a, {3'b0, ~exp_q & exp_prev});
         exp_prev = exp_q;
         last_d   = pat[i];
      end

      // ---- Reset mid-stream with o_q=1
      d_a = 1'b1;
      tick(); tick();
      check("mid_pre_q", q_a, 4'h1);
      rst_a = 1'b1;
      tick();
      check("mid_rst_q",    q_a,    4'h0);
      check("mid_rst_rise", rise_a, 4'h0);
      check("mid_rst_fall", fall_a, 4'h0);
      rst_a = 1'b0;
      tick();
      check("mid_rel1_q",    q_a,    4'h0);
      tick();
      check("mid_rel2_q",    q_a,    4'h1);
      check("mid_rel2_rise", rise_a, 4'h1);

      // ---- Wide DUT: reset value, then step to 5 after 3 edges
      check("w_rst_q",    q_b,    4'hA);
      check("w_rst_rise", rise_b, 4'h0);
      check("w_rst_fall", fall_b, 4'h0);
      rst_b = 1'b0; d_b = 4'h5;
      tick();
      check("w1_q", q_b, 4'hA);
      tick();
      check("w2_q",    q_b,    4'hA);
      check("w2_rise", rise_b, 4'h0);
      tick();
      check("w3_q",    q_b,    4'h5);
      check("w3_rise", rise_b, 4'h5);
      check("w3_fall", fall_b, 4'hA);
      tick();
      check("w4_rise", rise_b, 4'h0);
      check("w4_fall", fall_b, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_double_ff_synch
